ram_stream_reader: RTL and testbench
====================================

Name: ram_stream_reader

Overview:
- Read-side sequencer that sits directly downstream of the single-port coefficient/constant BRAM.
- On a start command it issues a burst of reads from a base address and absorbs the BRAM's 1-cycle registered read latency.
- It presents the words as a valid/ready stream with a last flag to the next arithmetic stage (NTT / poly multiply).
- Full-rate (1 word/cycle) under continuous ready; lossless under arbitrary backpressure.

Parameters:
- MEM_WIDTH, 32, data width; must match the attached RAM.
- MEM_SIZE, 24, RAM depth in words; ADDR_W = $clog2(MEM_SIZE) is derived, not overridable.
- LEN_W, $clog2(MEM_SIZE)+1, width of the burst length field; must hold the value MEM_SIZE.

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  command strobe; sampled only when busy=0.
- base_addr  in  ADDR_W  first word address.
- len  in  LEN_W  number of words to read, 0..MEM_SIZE.
- busy  out  1  burst in progress.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle pulse when a command is rejected.
- ram_en  out  1  RAM enable; the RAM's we is tied 0 at instantiation.
- ram_addr  out  ADDR_W  RAM address.
- ram_dout  in  MEM_WIDTH  RAM read data, valid the cycle after ram_en.
- m_data  out  MEM_WIDTH  stream data.
- m_valid  out  1  stream valid.
- m_last  out  1  marks the final word of the burst.
- m_ready  in  1  consumer ready.

Behaviour:
- Reset: busy, done, err, ram_en, m_valid, m_last = 0; ram_addr, m_data = 0; FSM = IDLE; buffer empty; in-flight flag cleared.
- Reset mid-burst aborts immediately. Any outstanding read's return data is discarded. No done is generated.
- FSM states: IDLE, RUN, DRAIN.
- IDLE:
  - start=1 with len=0 → done=1 next cycle; no reads; busy stays 0.
  - start=1 with base_addr>=MEM_SIZE or len>MEM_SIZE → err=1 next cycle; no reads.
  - Otherwise latch base/len, clear the issue counter, go to RUN; busy=1 from the next cycle.
- RUN: issue one read per cycle (ram_en=1, ram_addr=cur) when (occupancy + inflight − pop) < 2.
  - pop = m_valid & m_ready.
  - occupancy = entries in the 2-deep output buffer.
  - inflight = a read was issued in the previous cycle.
- Address wrap: cur starts at base and increments. After MEM_SIZE−1 it wraps to 0, so a burst may cross the top of the RAM.
- After len reads are issued, go to DRAIN. ram_en stays 0 from then on.
- DRAIN: wait until the buffer is empty and nothing is in flight; the final handshake carries m_last=1.
  - Cycle after that handshake: done=1, busy=0, FSM=IDLE.
  - A start in that same cycle is accepted.
- Latency: start sampled at edge E0 → ram_en=1 during cycle 1 → data captured into the buffer at E2 → m_valid=1 in cycle 3.
  - With m_ready held at 1: one word per cycle, and done comes len+3 cycles after E0.
- Backpressure: while m_valid=1 and m_ready=0, m_data and m_last hold stable. At most 2 words are buffered, so no read is ever issued without guaranteed space.
- m_last is asserted only with the len-th word. len=1 gives a single beat with m_last=1.
- start while busy=1 is ignored; no err is raised.
- ram_addr holds its last value when ram_en=0.

Decomposition:
- Shared package/header holds:
  - FSM state encodings (IDLE/RUN/DRAIN, 2 bits);
  - the ADDR_W/LEN_W derivation as constant functions;
  - the MEM_WIDTH default shared with the RAM.
- Sub-module skid_fifo2: a 2-entry synchronous FIFO carrying {last, data}, with push/pop/count, synchronous rst, and a registered output.
- Top level contains the FSM, address/issue counters and in-flight tracking.

Test Plan (RAM preloaded RAM[i]=0x100+i, MEM_SIZE=24):
- base=4, len=5, m_ready=1 → m_data 0x104..0x108 on consecutive cycles 3..7; m_last only on 0x108; done in cycle 8.
- base=21, len=6 → stream 0x115,0x116,0x117,0x100,0x101,0x102; ram_addr wraps 23→0.
- base=0, len=8, m_ready toggling 1,0,0,1,… → all 8 words in order, no loss or duplicates; m_data stable while stalled; never more than 2 buffered.
- len=0 → done one cycle after start, no ram_en, no m_valid. Then base=24, len=1 → err pulse, no reads.
- rst asserted during cycle 4 of a len=10 burst → next cycle all outputs at reset values, no done. A following base=0, len=2 burst then returns 0x100,0x101.
- start held high during a burst; back-to-back start in the done cycle → second burst is accepted, first burst is unaffected.

Source files
------------

// File: rtl/ram_stream_reader_pkg.sv
// ram_stream_reader_pkg: shared widths, defaults and FSM encodings for the BRAM stream reader
package ram_stream_reader_pkg;
  localparam int MEM_WIDTH_DEF = 32;
  localparam int MEM_SIZE_DEF = 24;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  function automatic int addr_w(input int size);
    return (size > 1) ? $clog2(size) : 1;
  endfunction
  function automatic int len_w(input int size);
    return $clog2(size) + 1;
  endfunction
endpackage

// File: rtl/ram_stream_reader_skid_fifo2.sv
// skid_fifo2: 2-entry synchronous FIFO with a registered head output
module skid_fifo2 #(
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic [W-1:0] i_din,
  input  logic         i_pop,
  output logic [W-1:0] o_dout,
  output logic [1:0]   o_count,
  output logic         o_valid
);
  logic [W-1:0] r_mem [2];
  logic [1:0]   r_count;
  logic         w_wr_idx;
  assign w_wr_idx = r_count[0] ^ i_pop;
  assign o_dout = r_mem[0];
  assign o_count = r_count;
  assign o_valid = r_count != 2'd0;
  // shift head on pop, then write the new entry behind whatever remains
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_count <= '0;
    end else begin
      if (i_pop) r_mem[0] <= r_mem[1];
      if (i_push) r_mem[w_wr_idx] <= i_din;
      r_count <= r_count + {1'b0, i_push} - {1'b0, i_pop};
    end
  end
endmodule

// File: rtl/ram_stream_reader.sv
// ram_stream_reader: burst reader turning BRAM reads into a valid/ready stream with last
module ram_stream_reader
  import ram_stream_reader_pkg::*;
#(
  parameter int MEM_WIDTH = MEM_WIDTH_DEF,
  parameter int MEM_SIZE = MEM_SIZE_DEF,
  parameter int LEN_W = len_w(MEM_SIZE)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [addr_w(MEM_SIZE)-1:0] base_addr,
  input  logic [LEN_W-1:0]          len,
  output logic                      busy,
  output logic                      done,
  output logic                      err,
  output logic                      ram_en,
  output logic [addr_w(MEM_SIZE)-1:0] ram_addr,
  input  logic [MEM_WIDTH-1:0]      ram_dout,
  output logic [MEM_WIDTH-1:0]      m_data,
  output logic                      m_valid,
  output logic                      m_last,
  input  logic                      m_ready
);
  localparam int ADDR_W = addr_w(MEM_SIZE);
  localparam logic [LEN_W-1:0] SIZE_L = LEN_W'(MEM_SIZE);
  localparam logic [ADDR_W-1:0] TOP_A = ADDR_W'(MEM_SIZE - 1);
  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_cur;
  logic [ADDR_W-1:0] r_ram_addr;
  logic [LEN_W-1:0]  r_issued;
  logic [LEN_W-1:0]  r_len;
  logic              r_inflight;
  logic              r_inflight_last;
  logic              r_done;
  logic              r_err;
  logic [MEM_WIDTH:0] w_head;
  logic [1:0]        w_cnt;
  logic              w_valid;
  logic              w_pop;
  logic              w_room;
  logic              w_issue;
  logic              w_final;
  logic              w_cmd;
  logic              w_bad;
  logic              w_accept;
  logic              w_end;
  assign w_pop = w_valid & m_ready;
  // a new read is only safe if buffered + in-flight words, after this cycle's pop, leave a free slot
  assign w_room = ({1'b0, w_cnt} + {2'b0, r_inflight}) < (3'd2 + {2'b0, w_pop});
  assign w_issue = (r_state == S_RUN) & w_room;
  assign w_final = r_issued == r_len - 1'b1;
  assign w_cmd = (r_state == S_IDLE) & start;
  assign w_bad = (LEN_W'(base_addr) >= SIZE_L) | (len > SIZE_L);
  assign w_accept = w_cmd & (len != '0) & ~w_bad;
  assign w_end = (r_state == S_DRAIN) & w_pop & m_last;
  assign busy = r_state != S_IDLE;
  assign done = r_done;
  assign err = r_err;
  assign ram_en = w_issue;
  assign ram_addr = w_issue ? r_cur : r_ram_addr;
  assign m_data = w_head[MEM_WIDTH-1:0];
  assign m_valid = w_valid;
  assign m_last = w_valid & w_head[MEM_WIDTH];
  // command decode, issue counters, wrap-around addressing and in-flight tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cur <= '0;
      r_ram_addr <= '0;
      r_issued <= '0;
      r_len <= '0;
      r_inflight <= 1'b0;
      r_inflight_last <= 1'b0;
      r_done <= 1'b0;
      r_err <= 1'b0;
    end else begin
      r_done <= (w_cmd & (len == '0)) | w_end;
      r_err <= w_cmd & (len != '0) & w_bad;
      r_inflight <= w_issue;
      r_inflight_last <= w_issue & w_final;
      if (w_issue) begin
        r_cur <= (r_cur == TOP_A) ? '0 : r_cur + 1'b1;
        r_issued <= r_issued + 1'b1;
        r_ram_addr <= r_cur;
      end
      if (w_accept) begin
        r_state <= S_RUN;
        r_cur <= base_addr;
        r_issued <= '0;
        r_len <= len;
      end else if (w_issue & w_final) begin
        r_state <= S_DRAIN;
      end else if (w_end) begin
        r_state <= S_IDLE;
      end
    end
  end
  skid_fifo2 #(.W(MEM_WIDTH + 1)) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .i_push (r_inflight),
    .i_din  ({r_inflight_last, ram_dout}),
    .i_pop  (w_pop),
    .o_dout (w_head),
    .o_count(w_cnt),
    .o_valid(w_valid)
  );
endmodule

// File: tb/tb_ram_stream_reader.sv
// tb_ram_stream_reader: directed self-checking bench for ram_stream_reader with a 24-word RAM model
module tb_ram_stream_reader;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [4:0]  base_addr = '0;
  logic [5:0]  len = '0;
  logic        busy, done, err, ram_en, m_valid, m_last;
  logic        m_ready = 1'b1;
  logic [4:0]  ram_addr;
  logic [31:0] ram_dout;
  logic [31:0] m_data;
  logic [31:0] mem [24];
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  always @(posedge clk) if (ram_en) ram_dout <= mem[ram_addr];

  ram_stream_reader dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .base_addr(base_addr),
    .len      (len),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .ram_en   (ram_en),
    .ram_addr (ram_addr),
    .ram_dout (ram_dout),
    .m_data   (m_data),
    .m_valid  (m_valid),
    .m_last   (m_last),
    .m_ready  (m_ready)
  );

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic launch(input int b, input int n);
    base_addr = 5'(b);
    len = 6'(n);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic reset_vals(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_ram_en"}, ram_en, 0);
    chk({tag, "_m_valid"}, m_valid, 0);
    chk({tag, "_m_last"}, m_last, 0);
    chk({tag, "_ram_addr"}, ram_addr, 0);
    chk({tag, "_m_data"}, m_data, 0);
  endtask

  // called in cycle 1 of a burst; follows it to its done pulse
  task automatic stream(input int b, input int n, input bit toggle, input int exp_done);
    int c, got, iss;
    bit stall;
    logic [31:0] pd;
    logic pl;
    c = 1; got = 0; iss = 0; stall = 0; pd = '0; pl = 1'b0;
    while (1) begin
      m_ready = toggle ? ((c % 3) == 1) : 1'b1;
      #1;
      chk("err_quiet", err, 0);
      chk("busy", busy, !done);
      if (ram_en) begin
        chk("ram_addr", ram_addr, (b + iss) % 24);
        iss++;
      end
      if (stall) begin
        chk("hold_valid", m_valid, 1);
        chk("hold_data", m_data, pd);
        chk("hold_last", m_last, pl);
      end
      if (m_valid && m_ready) begin
        if (!toggle) chk("beat_cycle", c, 3 + got);
        chk("data", m_data, 32'h100 + (b + got) % 24);
        chk("last", m_last, got == n - 1);
        got++;
      end
      chk("issued_le_len", iss <= n, 1);
      chk("occupancy_le_2", (iss - got) <= 2, 1);
      stall = m_valid && !m_ready;
      pd = m_data;
      pl = m_last;
      if (done) begin
        chk("beats", got, n);
        chk("done_no_valid", m_valid, 0);
        if (exp_done > 0) chk("done_cycle", c, exp_done);
        break;
      end
      if (c >= 300) begin
        checks++;
        failures++;
        $error("FAIL timeout observed=cycle %0d expected=done", c);
        break;
      end
      tick();
      c++;
    end
  endtask

  initial begin
    for (int i = 0; i < 24; i++) mem[i] = 32'h100 + i;
    repeat (2) tick();
    reset_vals("reset");
    rst = 1'b0;
    tick();
    launch(4, 5);
    stream(4, 5, 0, 8);
    tick();
    chk("t1_done_drop", done, 0);
    chk("t1_idle", busy, 0);
    launch(21, 6);
    stream(21, 6, 0, 9);
    tick();
    launch(0, 8);
    stream(0, 8, 1, -1);
    m_ready = 1'b1;
    tick();
    launch(3, 0);
    chk("len0_done", done, 1);
    chk("len0_busy", busy, 0);
    chk("len0_ram_en", ram_en, 0);
    chk("len0_valid", m_valid, 0);
    tick();
    chk("len0_done_drop", done, 0);
    chk("len0_ram_en2", ram_en, 0);
    launch(24, 1);
    chk("badbase_err", err, 1);
    chk("badbase_busy", busy, 0);
    chk("badbase_ram_en", ram_en, 0);
    chk("badbase_done", done, 0);
    tick();
    chk("badbase_err_drop", err, 0);
    chk("badbase_valid", m_valid, 0);
    launch(0, 25);
    chk("badlen_err", err, 1);
    chk("badlen_ram_en", ram_en, 0);
    tick();
    launch(0, 24);
    stream(0, 24, 0, 27);
    tick();
    launch(0, 10);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    reset_vals("midrst");
    rst = 1'b0;
    tick();
    chk("midrst_no_done", done, 0);
    chk("midrst_valid", m_valid, 0);
    chk("midrst_ram_en", ram_en, 0);
    launch(0, 2);
    stream(0, 2, 0, 5);
    tick();
    base_addr = 5'd4;
    len = 6'd3;
    start = 1'b1;
    tick();
    base_addr = 5'd10;
    len = 6'd2;
    stream(4, 3, 0, 6);
    tick();
    start = 1'b0;
    stream(10, 2, 0, 5);
    tick();
    chk("b2b_idle", busy, 0);
    chk("b2b_done_drop", done, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
